// File: rtl/md_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide sequencer.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  localparam int MD_ITER = 32;

  // Magnitude as unsigned; -2^31 maps to 0x8000_0000 naturally.
  function automatic logic [31:0] abs_op(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/md_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step.
module md_step (
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  input  logic        is_div,
  output logic [63:0] acc_nxt
);

  logic [32:0] sum;
  logic [32:0] diff;

  always_comb begin
    sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    // 33-bit remainder: the shifted remainder can exceed 32 bits before subtracting
    diff = acc[63:31] - {1'b0, opnd};
    if (is_div)
      acc_nxt = diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
    else
      acc_nxt = {sum, acc[31:1]};
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, with pipeline stall request.
//   state | meaning
//   IDLE  | accepting start or MTHI/MTLO
//   MUL   | 32 shift-add iterations
//   DIV   | 32 restoring-divide iterations
//   FIX   | sign correction, HI/LO write, done pulse
module md_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]  state;
  md_op_e      op;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] acc_nxt;
  logic [31:0] opnd;
  logic        s1;
  logic        s2;
  logic        in_signed;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic        op_signed;
  logic        neg;
  logic [63:0] prod;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign busy      = (state != IDLE);
  assign stall     = busy & (start | rd_req | hi_we | lo_we);
  assign in_signed = ~md_op[0];
  assign abs1      = abs_op(data1, in_signed);
  assign abs2      = abs_op(data2, in_signed);
  assign op_signed = ~op[0];
  assign neg       = op_signed & (s1 ^ s2);

  // Divide by zero keeps an all-ones quotient regardless of dividend sign.
  always_comb begin
    prod  = neg ? -acc : acc;
    q_fix = (neg && opnd != 32'd0) ? -acc[31:0] : acc[31:0];
    r_fix = (op_signed && s1) ? -acc[63:32] : acc[63:32];
  end

  md_step u_step (
    .acc    (acc),
    .opnd   (opnd),
    .is_div (state == DIV),
    .acc_nxt(acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op    <= MD_MULT;
      cnt   <= 5'd0;
      acc   <= 64'd0;
      opnd  <= 32'd0;
      s1    <= 1'b0;
      s2    <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op  <= md_op_e'(md_op);
              s1  <= in_signed & data1[31];
              s2  <= in_signed & data2[31];
              cnt <= 5'd0;
              if (md_op[1]) begin
                acc   <= {32'd0, abs1};
                opnd  <= abs2;
                state <= DIV;
              end else begin
                acc   <= {32'd0, abs2};
                opnd  <= abs1;
                state <= MUL;
              end
            end else begin
              if (hi_we) hi <= wdata;
              if (lo_we) lo <= wdata;
            end
          end
          MUL, DIV: begin
            acc <= acc_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'(MD_ITER - 1)) state <= FIX;
          end
          FIX: begin
            if (op[1]) begin
              hi <= r_fix;
              lo <= q_fix;
            end else begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with hand-computed HI/LO results and timing checks.
module tb_md_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        rd_req;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_fail = 0;

  md_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .md_op (md_op),
    .data1 (data1),
    .data2 (data2),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .rd_req(rd_req),
    .flush (flush),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents start for one edge (T0); returns at the negedge after T0 (n = 1).
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; data1 = a; data2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n counts negedges after T0; done is expected at n = 34 (written by edge T33).
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    launch(op, a, b);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(n);
    chk({tag, "_lat"}, 64'(n), 64'd34);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int dcount;
    rst_n = 1'b0; start = 1'b0; md_op = 2'b00; data1 = '0; data2 = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; rd_req = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("div_pos", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);

    // MFHI held from n=5, stray start at n=10 must be ignored
    launch(2'b11, 32'd100, 32'd7);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      rd_req = (n >= 5);
      start  = (n == 10);
      md_op  = 2'b01; data1 = 32'd3; data2 = 32'd3;
      #1;
      if (!done) chk("rd_stall", 64'(stall), (n >= 5) ? 64'd1 : 64'd0);
    end
    start = 1'b0;
    chk("rd_lat", 64'(n), 64'd34);
    chk("rd_stall_done", 64'(stall), 64'd0);
    chk("rd_hi", 64'(hi), 64'd2);
    chk("rd_lo", 64'(lo), 64'd14);
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_no_restart", 64'(busy), 64'd0);

    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h1234);
    chk("mtlo_hi", 64'(hi), 64'd2);

    launch(2'b01, 32'd6, 32'd7);
    @(negedge clk);
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD;
    #1;
    chk("mthi_stall", 64'(stall), 64'd1);
    @(negedge clk);
    chk("mthi_hold", 64'(hi), 64'd2);
    hi_we = 1'b0;
    wait_done(n);
    chk("mthi_hi", 64'(hi), 64'd0);
    chk("mthi_lo", 64'(lo), 64'd42);

    launch(2'b00, 32'hFFFF_FFFD, 32'd5);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'd0);
    chk("flush_lo", 64'(lo), 64'd42);
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("flush_nodone", 64'(dcount), 64'd0);
    chk("flush_lo_after", 64'(lo), 64'd42);

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (19) @(negedge clk);
    rd_req = 1'b1;
    rst_n  = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rd_req = 1'b0;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_stay_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Iterative multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline. It is the multi-cycle companion to the single-cycle ALU. It accepts MULT/MULTU/DIV/DIVU from EX, runs a 32-step shift-add or restoring-divide loop, and writes the HI/LO registers. It raises `stall` to the hazard logic whenever an instruction touching HI/LO meets a busy unit.

## Interface

Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  EX holds a MULT/MULTU/DIV/DIVU.
- `md_op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `data1`  in  32  rs operand (multiplicand or dividend).
- `data2`  in  32  rt operand (multiplier or divisor).
- `hi_we`  in  1  MTHI in EX.
- `lo_we`  in  1  MTLO in EX.
- `wdata`  in  32  MTHI/MTLO data.
- `rd_req`  in  1  MFHI/MFLO in EX.
- `flush`  in  1  kill the in-flight operation (exception or branch squash).
- `busy`  out  1  an operation is in flight.
- `stall`  out  1  freeze IF/ID/EX this cycle.
- `done`  out  1  one-cycle pulse when HI/LO are updated by an operation.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation

- FSM states:
  - IDLE.
  - MUL: 32 iterations.
  - DIV: 32 iterations.
  - FIX: sign correction and HI/LO write.
- IDLE with `start`=1 and `flush`=0:
  - Latch `md_op`.
  - Latch |data1| and |data2| as 32-bit unsigned. Signed ops only take the absolute value; |−2^31| = 0x8000_0000.
  - Latch the sign bits. Clear the counter and the 64-bit accumulator.
  - Next state is MUL or DIV.
- MUL: each cycle, add the multiplicand to the upper half if multiplier bit 0 is 1, then shift right 1. Counter increments; at count 31 → FIX.
- DIV: restoring divide. Each cycle, shift the remainder/quotient left 1, trial-subtract the divisor, and keep the result if it is non-negative, setting the quotient bit. At count 31 → FIX.
- FIX (signed ops only):
  - Product negated if s1^s2.
  - Quotient negated if s1^s2.
  - Remainder negated if s1.
  - HI ← product[63:32] or remainder; LO ← product[31:0] or quotient. `done`=1. Next state IDLE.
- Divide by zero (both DIV and DIVU): full latency, then LO=0xFFFF_FFFF and HI=original `data1`.
- Signed overflow, 0x8000_0000 / −1: LO=0x8000_0000, HI=0. This falls out of the algorithm and needs no special case.
- `hi_we`/`lo_we` while not busy: HI/LO ← `wdata` at the next edge. If `start` is also 1, `start` wins and the write is dropped.
- `stall` = `busy` & (`start` | `rd_req` | `hi_we` | `lo_we`). It is combinational. A new `start` while busy is ignored; the pipeline holds it until idle.
- `flush`, any state: next state IDLE, HI/LO unchanged, no `done`. `flush` with `start` in IDLE: `start` ignored.
- `hi` and `lo` are driven directly from the registers. MFHI/MFLO read them when `stall`=0.

## Timing

- Reset values: `busy`=0, `done`=0, `stall`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- `start` is sampled at edge T0.
- `busy`=1 from after T0 through the cycle ending at T33: MUL/DIV on T1..T32, FIX on T33.
- `hi`, `lo` and `done` are updated by T33. In the cycle after T33, `done`=1, `busy`=0, `stall`=0, and MFHI reads the new value.
- Latency from start to result is 33 cycles. A back-to-back `start` is accepted in the `done` cycle.
- `flush` at edge Tf: `busy`=0 in the cycle after Tf.
- `rst_n` low mid-operation: all outputs go to their reset values immediately. No partial HI/LO write.

## Structure

- Shared package `md_pkg`:
  - `md_op` encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - State enum: IDLE, MUL, DIV, FIX.
  - Constant `MD_ITER` = 32.
- One sub-module, `md_step`: a combinational single iteration. Inputs are the accumulator, operand and mode; output is the next accumulator. It is instantiated once in `md_sequencer`.

## Test plan

- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → after 33 cycles, HI=0xFFFF_FFFE, LO=0x0000_0001, one `done` pulse.
- MULT −3 × 5 → HI=0xFFFF_FFFF, LO=0xFFFF_FFF1. DIV −7 / 2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- DIVU 7 / 0 → LO=0xFFFF_FFFF, HI=7. DIV 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- `rd_req`=1 from cycle 5 of a divide → `stall`=1 through cycle 33 and 0 in the `done` cycle. A second `start` at cycle 10 is ignored, with no result change.
- MTLO 0x1234 while idle → LO=0x1234 next cycle. MTHI during busy → `stall`=1 and HI is unmodified until idle.
- `flush` at cycle 10 of a MULT → `busy`=0 at cycle 11 and HI/LO keep their prior values. `rst_n` low at cycle 20 → HI=LO=0 and `busy`=0 immediately.
